// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = 4;

  typedef enum logic {
    StArb  = 1'b0,
    StLock = 1'b1
  } arb_state_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter; flags when a denied requester has waited MaxVal cycles.
module starve_counter #(
  parameter int unsigned MaxVal = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  localparam logic [3:0] MaxCnt = 4'(MaxVal);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MaxCnt)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_max = (r_cnt == MaxCnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and a debug/loader master.
// CPU has priority; a starvation guard and a lock mode give the debug master access.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce,
  input  logic [BeW-1:0]    cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DataW-1:0]  cpu_wdata,
  output logic [DataW-1:0]  cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_lock,
  input  logic [BeW-1:0]    dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DataW-1:0]  dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DataW-1:0]  dbg_rdata,
  output logic              dbg_locked,
  output logic              ram_ena,
  output logic [BeW-1:0]    ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DataW-1:0]  ram_dina,
  input  logic [DataW-1:0]  ram_douta
);

  arb_state_e r_state, w_state_d;
  logic       r_rd_dbg;
  logic       w_at_max;
  logic       w_gnt_dbg;
  logic       w_gnt_cpu;
  logic       w_unused_addr;

  // Upper address bits are outside the RAM and intentionally dropped.
  assign w_unused_addr = ^{cpu_addr[31:ADDR_W], dbg_addr[31:ADDR_W]};

  assign w_state_d = dbg_lock ? StLock : StArb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StArb;
      r_rd_dbg <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rd_dbg <= w_gnt_dbg & (dbg_we == '0);
    end
  end

  // Grants are forced low during reset so nothing reaches the RAM.
  always_comb begin
    w_gnt_dbg = 1'b0;
    w_gnt_cpu = 1'b0;
    if (!rst) begin
      if (r_state == StLock) begin
        w_gnt_dbg = dbg_req;
      end else begin
        w_gnt_dbg = dbg_req & (~cpu_ce | w_at_max);
        w_gnt_cpu = cpu_ce & ~w_gnt_dbg;
      end
    end
  end

  starve_counter #(
    .MaxVal (MAX_WAIT)
  ) u_starve_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (~dbg_req | w_gnt_dbg | (w_state_d == StLock)),
    .i_inc    (dbg_req & ~w_gnt_dbg),
    .o_at_max (w_at_max)
  );

  always_comb begin
    ram_ena  = w_gnt_dbg | w_gnt_cpu;
    ram_wea  = '0;
    ram_addr = cpu_addr[ADDR_W-1:0];
    ram_dina = cpu_wdata;
    if (w_gnt_dbg) begin
      ram_wea  = dbg_we;
      ram_addr = dbg_addr[ADDR_W-1:0];
      ram_dina = dbg_wdata;
    end else if (w_gnt_cpu) begin
      ram_wea  = cpu_we;
    end
  end

  assign cpu_stall  = ~rst & cpu_ce & ~w_gnt_cpu;
  assign dbg_gnt    = w_gnt_dbg;
  assign dbg_rvalid = r_rd_dbg;
  assign dbg_rdata  = ram_douta;
  assign cpu_rdata  = ram_douta;
  assign dbg_locked = (r_state == StLock);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM (`ram`, 1-cycle read latency, 4-bit byte write enables) between the CPU data port of `top` and a debug/loader master.
- The CPU has priority. The debug master is served in idle cycles, and a starvation guard forces a debug grant after a bounded wait.
- A lock mode gives the debug master exclusive ownership for bulk program/data loads while the CPU is stalled.
- Sits between `top` and `ram`.

Parameters:
- ADDR_W, 10, RAM address width; `ram_addr` = selected `addr[ADDR_W-1:0]`.
- MAX_WAIT, 4, consecutive cycles a pending debug request may be denied before forced grant (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_ce  in  1  CPU data access request (`dce`).
- cpu_we  in  4  CPU byte write enables; 0 = read.
- cpu_addr  in  32  CPU data address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  read data to CPU (`dm`).
- cpu_stall  out  1  CPU access not performed this cycle; CPU must hold its request.
- dbg_req  in  1  debug access request; held with its fields until granted.
- dbg_lock  in  1  request exclusive ownership.
- dbg_we  in  4  debug byte write enables.
- dbg_addr  in  32  debug address.
- dbg_wdata  in  32  debug write data.
- dbg_gnt  out  1  debug access issued to RAM this cycle.
- dbg_rvalid  out  1  `dbg_rdata` valid (one cycle after a granted debug read).
- dbg_rdata  out  32  debug read data.
- dbg_locked  out  1  arbiter is in LOCK state.
- ram_ena  out  1  RAM enable.
- ram_wea  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_dina  out  32  RAM write data.
- ram_douta  in  32  RAM read data, valid the cycle after a read is issued.

Behaviour:
- Reset values:
  - state = ARB; starve_cnt = 0; dbg_rvalid = 0; dbg_locked = 0.
  - dbg_gnt = 0 and cpu_stall = 0 while rst is high.
  - ram_ena = 0, ram_wea = 0.
- Reset mid-transaction: any pending read-return is dropped, no dbg_rvalid follows, and the lock is released.
- State ARB:
  - Grant decision is combinational: `gnt_dbg = dbg_req & (~cpu_ce | starve_cnt == MAX_WAIT)`.
  - `gnt_cpu = cpu_ce & ~gnt_dbg`.
  - `cpu_stall = cpu_ce & gnt_dbg`.
  - `dbg_gnt = gnt_dbg`.
- Starvation counter:
  - starve_cnt increments when `dbg_req & ~gnt_dbg`.
  - It clears on `gnt_dbg` or `~dbg_req`.
  - It saturates at MAX_WAIT.
- Transition ARB -> LOCK: on a clock edge with `dbg_lock = 1`. starve_cnt clears.
- State LOCK:
  - `dbg_gnt = dbg_req`; `cpu_stall = cpu_ce`. The CPU never reaches the RAM.
  - dbg_locked = 1.
  - Transition LOCK -> ARB on a clock edge with `dbg_lock = 0`.
- RAM mux:
  - The granted requester drives `ram_ena = 1`, `ram_wea`, `ram_addr = addr[ADDR_W-1:0]` (upper bits ignored) and `ram_dina`.
  - With no grant, `ram_ena = 0` and `ram_wea = 0`.
- Read return:
  - A registered flag `rd_dbg` is set when a debug read (`we = 0`) is granted.
  - `dbg_rvalid = rd_dbg`, one cycle after `dbg_gnt`.
  - `dbg_rdata = ram_douta`.
  - `cpu_rdata = ram_douta` unconditionally. The CPU samples it only for its own reads; the pipeline already assumes 1-cycle latency.
- Writes produce no response beyond `dbg_gnt`.
- Simultaneous cpu_ce and dbg_req with starve_cnt < MAX_WAIT: the CPU wins, and starve_cnt increments.
- dbg_lock asserted while a debug read is returning: the read still returns on schedule; the lock takes effect on the same edge.
- Back-to-back debug reads: one per cycle; dbg_rvalid stays high continuously.

Decomposition:
- Shared package `dmem_pkg`: state encoding (ARB = 1'b0, LOCK = 1'b1), RAM data width 32, byte-enable width 4.
- Optional sub-module `starve_counter` (saturating counter with clear/inc and an `at_max` flag). Everything else stays inline.

Test Plan:
- CPU only: cpu_ce = 1, cpu_we = 4'hF, cpu_addr = 0x10, cpu_wdata = 0xDEADBEEF, then a read of 0x10 -> ram_wea = F, ram_addr = 0x010; next cycle cpu_rdata = 0xDEADBEEF; cpu_stall stays 0.
- Debug in an idle cycle: cpu_ce = 0, dbg_req = 1, dbg read of 0x10 -> dbg_gnt = 1 in the same cycle; dbg_rvalid = 1 with dbg_rdata = 0xDEADBEEF one cycle later.
- Starvation (MAX_WAIT = 4): cpu_ce held at 1 and dbg_req held at 1 from cycle 0 -> dbg denied in cycles 0–3; cycle 4 gives dbg_gnt = 1 and cpu_stall = 1; cycle 5 returns to the CPU with starve_cnt = 0.
- Lock load: dbg_lock = 1, then 8 debug writes to 0..7 with cpu_ce = 1 throughout -> dbg_locked = 1, cpu_stall = 1 every cycle, RAM words 0..7 written; after dbg_lock = 0, the CPU resumes on the next cycle.
- Byte enables: dbg_we = 4'b0010 with wdata 0x0000AB00 to a word holding 0x11223344 -> word reads back 0x1122AB44.
- Reset mid-read: grant a debug read, assert rst before the next edge -> dbg_rvalid stays 0, dbg_locked = 0, ram_ena = 0.
